fpu_multiplier: RTL



---
 rtl/fpu_pkg.sv | 46 ++++
 rtl/fpu_multiplier.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg
//   Shared constants, state encodings and operand classification helpers for
//   the single-precision FPU blocks (fpu_multiplier and fpu_adder).
//   Exponents are carried unbiased as 10-bit signed values so that the
//   intermediate range (roughly -300..+300) never wraps.
package fpu_pkg;

  typedef logic signed [9:0] exp_t;

  // FSM state encodings, 4 bits wide.
  localparam logic [3:0] ST_GET_A   = 4'd0;
  localparam logic [3:0] ST_GET_B   = 4'd1;
  localparam logic [3:0] ST_UNPACK  = 4'd2;
  localparam logic [3:0] ST_SPECIAL = 4'd3;
  localparam logic [3:0] ST_NORM_A  = 4'd4;
  localparam logic [3:0] ST_NORM_B  = 4'd5;
  localparam logic [3:0] ST_MUL_0   = 4'd6;
  localparam logic [3:0] ST_MUL_1   = 4'd7;
  localparam logic [3:0] ST_NORM_1  = 4'd8;
  localparam logic [3:0] ST_NORM_2  = 4'd9;
  localparam logic [3:0] ST_ROUND   = 4'd10;
  localparam logic [3:0] ST_PACK    = 4'd11;
  localparam logic [3:0] ST_PUT_Z   = 4'd12;

  localparam int          BIAS     = 127;
  localparam logic [7:0]  EXP_INF  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'hFFC00000;
  localparam exp_t        E_MIN    = -10'sd126;
  localparam exp_t        E_DENORM = -10'sd127;
  localparam exp_t        E_INF    = 10'sd128;

  // Classification works on the unpacked form, where the hidden bit has not
  // been inserted yet, so m holds only the stored fraction.
  function automatic logic isNan(input exp_t e, input logic [23:0] m);
    return (e == E_INF) && (m != 24'd0);
  endfunction

  function automatic logic isInf(input exp_t e, input logic [23:0] m);
    return (e == E_INF) && (m == 24'd0);
  endfunction

  function automatic logic isZero(input exp_t e, input logic [23:0] m);
    return (e == E_DENORM) && (m == 24'd0);
  endfunction

endpackage

// File: rtl/fpu_multiplier.sv
// fpu_multiplier
//   IEEE-754 single-precision multiplier built as a multi-cycle FSM. Operands
//   arrive one at a time over strobe/ack word transfers; the product is held
//   on output_z and announced with a single-cycle output_z_stb pulse.
//   Latency depends on how many normalisation shifts the operands need.
//
// Ports
//   clk          : clock, everything on the rising edge
//   rst          : synchronous active-low reset
//   input_a      : operand A (IEEE single)
//   input_a_stb  : operand A valid
//   input_a_ack  : block ready to take A
//   input_b      : operand B (IEEE single)
//   input_b_stb  : operand B valid
//   input_b_ack  : block ready to take B
//   output_z     : product, held until the next result
//   output_z_stb : one-cycle result-valid pulse
module fpu_multiplier
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb
);

  logic [3:0]  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [23:0] a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  exp_t        a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic        a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic        guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic [47:0] product_q, product_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [31:0] out_z_q, out_z_d;
  logic        out_stb_q, out_stb_d;

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = out_z_q;
  assign output_z_stb = out_stb_q;

  // Next-state logic: every register holds by default and each state only
  // touches what it owns. The result strobe defaults low so put_z produces a
  // single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    a_m_d     = a_m_q;
    b_m_d     = b_m_q;
    z_m_d     = z_m_q;
    a_e_d     = a_e_q;
    b_e_d     = b_e_q;
    z_e_d     = z_e_q;
    a_s_d     = a_s_q;
    b_s_d     = b_s_q;
    z_s_d     = z_s_q;
    guard_d   = guard_q;
    round_d   = round_q;
    sticky_d  = sticky_q;
    product_d = product_q;
    a_ack_d   = a_ack_q;
    b_ack_d   = b_ack_q;
    out_z_d   = out_z_q;
    out_stb_d = 1'b0;

    case (state_q)
      // ack rises one cycle after entry, so the earliest capture is the
      // second cycle spent here.
      ST_GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          state_d = ST_GET_B;
        end
      end

      ST_GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d     = input_b;
          b_ack_d = 1'b0;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        a_m_d   = {1'b0, a_q[22:0]};
        b_m_d   = {1'b0, b_q[22:0]};
        a_e_d   = $signed({2'b00, a_q[30:23]}) - exp_t'(BIAS);
        b_e_d   = $signed({2'b00, b_q[30:23]}) - exp_t'(BIAS);
        a_s_d   = a_q[31];
        b_s_d   = b_q[31];
        state_d = ST_SPECIAL;
      end

      // Checks are in priority order; inf times zero is invalid.
      ST_SPECIAL: begin
        if (isNan(a_e_q, a_m_q) || isNan(b_e_q, b_m_q)) begin
          z_d     = QNAN;
          state_d = ST_PUT_Z;
        end else if (isInf(a_e_q, a_m_q)) begin
          z_d     = isZero(b_e_q, b_m_q) ? QNAN : {a_s_q ^ b_s_q, EXP_INF, 23'd0};
          state_d = ST_PUT_Z;
        end else if (isInf(b_e_q, b_m_q)) begin
          z_d     = isZero(a_e_q, a_m_q) ? QNAN : {a_s_q ^ b_s_q, EXP_INF, 23'd0};
          state_d = ST_PUT_Z;
        end else if (isZero(a_e_q, a_m_q) || isZero(b_e_q, b_m_q)) begin
          z_d     = {a_s_q ^ b_s_q, 31'd0};
          state_d = ST_PUT_Z;
        end else begin
          // Denormals have no hidden bit and sit at the minimum exponent.
          if (a_e_q == E_DENORM) a_e_d = E_MIN;
          else                   a_m_d[23] = 1'b1;
          if (b_e_q == E_DENORM) b_e_d = E_MIN;
          else                   b_m_d[23] = 1'b1;
          state_d = ST_NORM_A;
        end
      end

      ST_NORM_A: begin
        if (!a_m_q[23]) begin
          a_m_d = {a_m_q[22:0], 1'b0};
          a_e_d = a_e_q - 10'sd1;
        end else begin
          state_d = ST_NORM_B;
        end
      end

      ST_NORM_B: begin
        if (!b_m_q[23]) begin
          b_m_d = {b_m_q[22:0], 1'b0};
          b_e_d = b_e_q - 10'sd1;
        end else begin
          state_d = ST_MUL_0;
        end
      end

      // The +1 accounts for taking the upper 24 bits of a product whose
      // leading one may land on bit 47.
      ST_MUL_0: begin
        z_s_d     = a_s_q ^ b_s_q;
        z_e_d     = a_e_q + b_e_q + 10'sd1;
        product_d = {24'd0, a_m_q} * {24'd0, b_m_q};
        state_d   = ST_MUL_1;
      end

      ST_MUL_1: begin
        z_m_d    = product_q[47:24];
        guard_d  = product_q[23];
        round_d  = product_q[22];
        sticky_d = |product_q[21:0];
        state_d  = ST_NORM_1;
      end

      ST_NORM_1: begin
        if (!z_m_q[23] && (z_e_q > E_MIN)) begin
          z_e_d   = z_e_q - 10'sd1;
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
        end else begin
          state_d = ST_NORM_2;
        end
      end

      // Results below the minimum exponent are denormalised; bits shifted
      // out collapse into sticky so rounding still sees them.
      ST_NORM_2: begin
        if (z_e_q < E_MIN) begin
          z_e_d    = z_e_q + 10'sd1;
          z_m_d    = {1'b0, z_m_q[23:1]};
          guard_d  = z_m_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = ST_ROUND;
        end
      end

      // Round to nearest even; a mantissa carry-out wraps to zero and bumps
      // the exponent, which is exactly 1.0 at the next binade.
      ST_ROUND: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
        end
        state_d = ST_PACK;
      end

      ST_PACK: begin
        z_d[31]    = z_s_q;
        z_d[30:23] = 8'(z_e_q + exp_t'(BIAS));
        z_d[22:0]  = z_m_q[22:0];
        if ((z_e_q == E_MIN) && !z_m_q[23]) z_d[30:23] = 8'd0;
        if (z_e_q >= E_INF)                 z_d = {z_s_q, EXP_INF, 23'd0};
        state_d = ST_PUT_Z;
      end

      ST_PUT_Z: begin
        out_z_d   = z_q;
        out_stb_d = 1'b1;
        state_d   = ST_GET_A;
      end

      default: state_d = ST_GET_A;
    endcase
  end

  // State registers. A reset in the middle of an operation simply drops the
  // work in flight; no result strobe follows it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_GET_A;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      a_m_q     <= '0;
      b_m_q     <= '0;
      z_m_q     <= '0;
      a_e_q     <= '0;
      b_e_q     <= '0;
      z_e_q     <= '0;
      a_s_q     <= 1'b0;
      b_s_q     <= 1'b0;
      z_s_q     <= 1'b0;
      guard_q   <= 1'b0;
      round_q   <= 1'b0;
      sticky_q  <= 1'b0;
      product_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      out_z_q   <= '0;
      out_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      z_q       <= z_d;
      a_m_q     <= a_m_d;
      b_m_q     <= b_m_d;
      z_m_q     <= z_m_d;
      a_e_q     <= a_e_d;
      b_e_q     <= b_e_d;
      z_e_q     <= z_e_d;
      a_s_q     <= a_s_d;
      b_s_q     <= b_s_d;
      z_s_q     <= z_s_d;
      guard_q   <= guard_d;
      round_q   <= round_d;
      sticky_q  <= sticky_d;
      product_q <= product_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      out_z_q   <= out_z_d;
      out_stb_q <= out_stb_d;
    end
  end

endmodule
